// File: rtl/instruction_fetch.sv
// Instruction fetch unit: four-state fetch FSM holding one instruction word and its pc.
// Optional fetch watchdog is enabled with `define FETCH_TIMEOUT_EN.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC       = 64'h0,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        branch,
    input  logic [63:0] branch_target,
    input  logic        stall,
    output logic [31:0] instruction,
    output logic [6:0]  opcode,
    output logic [63:0] pc,
    output logic        valid,
    output logic        fetch_timeout
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [63:0] pc_r, pc_nxt;
    logic [63:0] tgt_r, tgt_nxt;
    logic [31:0] instr_r, instr_nxt;
    logic        valid_r, valid_nxt;
    logic        req_st;
    logic        to_hit;
    logic        ack_eff;
    logic [63:0] tgt_aligned;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 8-bit fetch watchdog");
    end

    assign req_st      = (state == FETCH) || (state == FLUSH);
    assign imem_req    = req_st && !to_hit;
    assign ack_eff     = imem_req && imem_ack;
    assign tgt_aligned = {branch_target[63:2], 2'b00};

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
    logic [7:0] wd_cnt;

    // The timeout cycle itself drops the request; the same address is reissued next cycle.
    assign to_hit        = req_st && (wd_cnt == TO_LIM);
    assign fetch_timeout = to_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            wd_cnt <= 8'd0;
        else if (!req_st || ack_eff || to_hit || (state_nxt != state))
            wd_cnt <= 8'd0;
        else
            wd_cnt <= wd_cnt + 8'd1;
    end
`else
    assign to_hit        = 1'b0;
    assign fetch_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_r;
        tgt_nxt   = tgt_r;
        instr_nxt = instr_r;
        valid_nxt = valid_r;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (ack_eff) begin
                    if (branch) begin
                        // Redirect wins over the returning word, which is dropped.
                        pc_nxt    = tgt_aligned;
                        valid_nxt = 1'b0;
                    end else begin
                        instr_nxt = imem_data;
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (branch) begin
                    tgt_nxt   = tgt_aligned;
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // The in-flight access must complete before the redirect takes effect.
                if (ack_eff) begin
                    pc_nxt    = tgt_r;
                    state_nxt = FETCH;
                end
            end
            HOLD: begin
                if (!stall) begin
                    valid_nxt = 1'b0;
                    pc_nxt    = branch ? tgt_aligned : pc_r + 64'd4;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pc_r    <= RESET_PC;
            tgt_r   <= 64'd0;
            instr_r <= 32'd0;
            valid_r <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_r    <= pc_nxt;
            tgt_r   <= tgt_nxt;
            instr_r <= instr_nxt;
            valid_r <= valid_nxt;
        end
    end

    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign instruction = instr_r;
    assign opcode      = instr_r[6:0];
    assign valid       = valid_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then random traffic against a
// transaction-level model of the fetch/hold/redirect rules.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        branch;
    logic [63:0] branch_target;
    logic        stall;
    logic [31:0] instruction;
    logic [6:0]  opcode;
    logic [63:0] pc;
    logic        valid;
    logic        fetch_timeout;

    int tests = 0;
    int fails = 0;

    // Model: word held for the pipeline, address of the next fetch,
    // whether a memory read is outstanding, and redirects waiting on that read.
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_req;
    logic [63:0] m_redir[$];

    instruction_fetch dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .branch(branch), .branch_target(branch_target), .stall(stall),
        .instruction(instruction), .opcode(opcode), .pc(pc),
        .valid(valid), .fetch_timeout(fetch_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 64'h0;
        m_instr = 32'h0;
        m_valid = 1'b0;
        m_req   = 1'b0;
        m_redir.delete();
    endtask

    task automatic model_update(input logic a, input logic [31:0] d, input logic b,
                                input logic [63:0] t, input logic s);
        logic [63:0] ta;
        ta = t & ~64'h3;
        if (m_req) begin
            if (m_redir.size() != 0) begin
                if (a) m_pc = m_redir.pop_front();
            end else if (a) begin
                if (b) m_pc = ta;
                else begin
                    m_instr = d;
                    m_valid = 1'b1;
                    m_req   = 1'b0;
                end
            end else if (b) begin
                m_redir.push_back(ta);
            end
        end else if (m_valid) begin
            if (!s) begin
                m_valid = 1'b0;
                m_pc    = b ? ta : m_pc + 64'd4;
                m_req   = 1'b1;
            end
        end else begin
            m_req = 1'b1;
        end
    endtask

    // Drive one cycle of inputs, compare outputs to the model, clock, advance the model.
    task automatic step(input logic a, input logic [31:0] d, input logic b,
                        input logic [63:0] t, input logic s);
        imem_ack      = a;
        imem_data     = d;
        branch        = b;
        branch_target = t;
        stall         = s;
        chk("imem_req", 64'(imem_req), 64'(m_req));
        chk("imem_addr", imem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("valid", 64'(valid), 64'(m_valid));
        chk("instruction", 64'(instruction), 64'(m_instr));
        chk("opcode", 64'(opcode), 64'(m_instr[6:0]));
        chk("fetch_timeout", 64'(fetch_timeout), 64'd0);
        @(posedge clock);
        #1;
        model_update(a, d, b, t, s);
    endtask

    initial begin
        reset = 1'b1;
        imem_ack = 1'b0; imem_data = 32'h0; branch = 1'b0;
        branch_target = 64'h0; stall = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_pc", pc, 64'h0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_instr", 64'(instruction), 64'd0);
        chk("rst_timeout", 64'(fetch_timeout), 64'd0);
        reset = 1'b0;

        // zero-wait fetch of an R-type word, then sequential advance
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 64'h0, 1'b0);
        step(1'b1, 32'h00A30033, 1'b0, 64'h0, 1'b0);
        chk("zw_valid", 64'(valid), 64'd1);
        chk("zw_opcode", 64'(opcode), 64'h33);
        step(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
        chk("seq_addr", imem_addr, 64'h4);
        chk("seq_valid", 64'(valid), 64'd0);

        // branch from HOLD with a misaligned target
        step(1'b1, $urandom, 1'b0, 64'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 64'h10, 1'b0);
        step(1'b1, $urandom, 1'b0, 64'h0, 1'b0);
        chk("hold_pc10", pc, 64'h10);
        step(1'b0, 32'h0, 1'b1, 64'h47, 1'b0);
        chk("br_align", imem_addr, 64'h44);

        // branch coincident with ack: word dropped, stay fetching at target
        step(1'b1, $urandom, 1'b1, 64'h8, 1'b0);
        chk("br_ack_addr", imem_addr, 64'h8);
        chk("br_ack_valid", 64'(valid), 64'd0);

        // branch without ack: flush, later branches ignored, ack data discarded
        step(1'b0, 32'h0, 1'b1, 64'h100, 1'b0);
        chk("flush_addr", imem_addr, 64'h8);
        chk("flush_req", 64'(imem_req), 64'd1);
        step(1'b0, 32'h0, 1'b1, 64'h200, 1'b0);
        step(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
        step(1'b1, 32'h00000003, 1'b1, 64'h300, 1'b0);
        chk("flush_valid", 64'(valid), 64'd0);
        chk("flush_tgt", imem_addr, 64'h100);

        // stall for 5 cycles in HOLD with noisy ack/branch
        step(1'b1, $urandom, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom), $urandom, 1'($urandom), {$urandom, $urandom}, 1'b1);
            chk("stall_req", 64'(imem_req), 64'd0);
            chk("stall_pc", pc, 64'h100);
            chk("stall_valid", 64'(valid), 64'd1);
        end

        // pc+4 wraps
        step(1'b0, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("wrap_pre", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b1, $urandom, 1'b0, 64'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
        chk("wrap_addr", imem_addr, 64'h0);

        // reset asserted mid-fetch, ack afterwards ignored
        step(1'b0, 32'h0, 1'b1, 64'h5_0000, 1'b0);
        imem_ack = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_req", 64'(imem_req), 64'd0);
        chk("mid_rst_pc", pc, 64'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        step(1'b1, 32'h1234_5678, 1'b1, 64'h40, 1'b0);

        for (int i = 0; i < 400; i++)
            step(1'($urandom), $urandom, ($urandom_range(0, 3) == 0),
                 {$urandom, $urandom}, ($urandom_range(0, 2) == 0));

`ifdef FETCH_TIMEOUT_EN
        reset = 1'b1;
        #1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        imem_ack = 1'b0; branch = 1'b0; stall = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 255; i++) begin
            chk("wd_quiet", 64'(fetch_timeout), 64'd0);
            chk("wd_req", 64'(imem_req), 64'd1);
            @(posedge clock);
            #1;
        end
        chk("wd_pulse", 64'(fetch_timeout), 64'd1);
        chk("wd_drop", 64'(imem_req), 64'd0);
        @(posedge clock);
        #1;
        chk("wd_end", 64'(fetch_timeout), 64'd0);
        chk("wd_reissue", 64'(imem_req), 64'd1);
        chk("wd_addr", imem_addr, 64'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, is the PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, is the fetch watchdog limit used only when FETCH_TIMEOUT_EN is defined.
REQ-003 The clock is clock, input, 1 bit; all state changes on its rising edge.
REQ-004 The reset is reset, input, 1 bit, asynchronous and active-high.
REQ-005 imem_req, output, 1 bit, is the instruction-memory read request.
REQ-006 imem_addr, output, 64 bits, is the fetch address, equal to pc.
REQ-007 imem_ack, input, 1 bit, means imem_data is valid this cycle.
REQ-008 imem_data, input, 32 bits, is the fetched instruction word.
REQ-009 branch, input, 1 bit, is the taken-branch redirect (branch AND zero).
REQ-010 branch_target, input, 64 bits, is the redirect address.
REQ-011 stall, input, 1 bit, holds the current instruction when high.
REQ-012 instruction, output, 32 bits, is the held instruction word.
REQ-013 opcode, output, 7 bits, equals instruction[6:0] and feeds the controller.
REQ-014 pc, output, 64 bits, is the address of the current or pending instruction.
REQ-015 valid, output, 1 bit, is high while instruction/opcode are usable.
REQ-016 fetch_timeout, output, 1 bit, is a one-cycle watchdog pulse; it is constant 0 when FETCH_TIMEOUT_EN is undefined.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, HOLD and FLUSH; imem_req SHALL be 1 exactly in FETCH and FLUSH.
REQ-018 IDLE SHALL go to FETCH on the next clock unconditionally.
REQ-019 In FETCH, imem_ack=1 and branch=0 SHALL capture imem_data into instruction, set valid=1, and go to HOLD.
REQ-020 In FETCH, branch=1 and imem_ack=1 in the same cycle SHALL discard the data, set pc to branch_target, and stay in FETCH with valid=0.
REQ-021 In FETCH, branch=1 and imem_ack=0 SHALL latch branch_target and go to FLUSH.
REQ-022 In FLUSH, imem_ack=1 SHALL discard the data, set pc to the latched target, and go to FETCH; branch SHALL be ignored in FLUSH.
REQ-023 In HOLD, stall=1 SHALL keep pc, instruction and valid unchanged, and branch SHALL be ignored.
REQ-024 In HOLD, stall=0 SHALL set valid=0, set pc to branch_target if branch=1 or to pc+4 otherwise, and go to FETCH.
REQ-025 pc+4 SHALL wrap modulo 2^64; branch_target[1:0] SHALL be forced to 2'b00 when loaded.
REQ-026 imem_addr SHALL stay stable while imem_req=1; imem_ack SHALL be ignored while imem_req=0.
REQ-027 With zero-wait memory (ack in the first FETCH cycle), consecutive instructions SHALL present valid every second cycle.

Reset
REQ-028 While reset=1, the state SHALL be IDLE, pc=RESET_PC, instruction=0, valid=0, imem_req=0, fetch_timeout=0, and the latched target and watchdog SHALL be cleared.
REQ-029 Reset asserted mid-fetch SHALL abandon the outstanding request, and any ack arriving afterwards SHALL be ignored.

Configuration
REQ-030 With FETCH_TIMEOUT_EN defined, an 8-bit counter SHALL count cycles spent in FETCH or FLUSH without an ack, and SHALL clear on ack or on a state change.
REQ-031 With FETCH_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL pulse fetch_timeout for one cycle, drop imem_req for that cycle, clear the counter, and reissue the request to the same address.
REQ-032 With FETCH_TIMEOUT_EN undefined, the counter SHALL be absent, fetch_timeout SHALL be tied to 0, and a request SHALL wait for its ack indefinitely.

Verification
REQ-033 Reset release with RESET_PC=0 and ack in the same cycle as the request, data 32'h00A30033, then stall=0: valid rises with opcode=7'b0110011, and the next imem_addr is 0x4.
REQ-034 In HOLD at pc=0x10, stall=0 and branch=1 with target 0x47: the next imem_addr is 0x44.
REQ-035 In FETCH at pc=0x8, branch=1 with target 0x100 and ack delayed 3 cycles: the state goes to FLUSH, data 32'h00000003 is discarded with valid=0, and the next imem_addr is 0x100.
REQ-036 pc=64'hFFFF_FFFF_FFFF_FFFC in HOLD with stall=0: the next imem_addr is 0x0.
REQ-037 stall held high for 5 cycles in HOLD: instruction, pc and valid are unchanged and imem_req=0 throughout.
REQ-038 With FETCH_TIMEOUT_EN defined and no ack: fetch_timeout pulses after 255 cycles, imem_req drops for 1 cycle, and is then reasserted at the same address.
